// File: rtl/demux4_fifo.sv
// rtl/demux4_fifo.sv - 1-to-4 stream demultiplexer with an independent FIFO per output channel.
// Head data is combinational from the FIFO; an empty channel keeps showing its last head.
module demux4_fifo #(
    parameter int W     = 2,
    parameter int DEPTH = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [1:0]   in_sel,
    input  logic [W-1:0] in_data,
    output logic [3:0]   out_valid,
    input  logic [3:0]   out_ready,
    output logic [W-1:0] out_data0,
    output logic [W-1:0] out_data1,
    output logic [W-1:0] out_data2,
    output logic [W-1:0] out_data3,
    output logic [7:0]   xfer_cnt
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0]   C_FULL  = (AW+1)'(DEPTH);
    localparam logic [AW:0]   C_ONE   = (AW+1)'(1);
    localparam logic [AW-1:0] C_PSTEP = AW'(1);

    logic [3:0]   w_full;
    logic [3:0]   w_push;
    logic [3:0]   w_pop;
    logic [W-1:0] w_head [4];
    logic [7:0]   r_xfer;

    // A full channel never accepts, even when it pops this cycle.
    assign in_ready = !w_full[in_sel];

    for (genvar g = 0; g < 4; g++) begin : g_ch
        logic [W-1:0]  r_mem [DEPTH];
        logic [AW-1:0] r_wptr;
        logic [AW-1:0] r_rptr;
        logic [AW:0]   r_cnt;
        logic [W-1:0]  r_last;

        assign w_full[g]    = (r_cnt == C_FULL);
        assign out_valid[g] = (r_cnt != '0);
        assign w_push[g]    = in_valid && in_ready && (in_sel == 2'(g));
        assign w_pop[g]     = out_valid[g] && out_ready[g];
        assign w_head[g]    = out_valid[g] ? r_mem[r_rptr] : r_last;

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                r_wptr <= '0;
                r_rptr <= '0;
                r_cnt  <= '0;
                r_last <= '0;
            end else begin
                if (w_push[g]) r_wptr <= r_wptr + C_PSTEP;
                if (w_pop[g])  r_rptr <= r_rptr + C_PSTEP;
                if (w_push[g] && !w_pop[g])
                    r_cnt <= r_cnt + C_ONE;
                else if (!w_push[g] && w_pop[g])
                    r_cnt <= r_cnt - C_ONE;
                // Remember the visible head so it stays on the port once drained.
                if (out_valid[g]) r_last <= r_mem[r_rptr];
            end
        end

        always_ff @(posedge clk) begin
            if (w_push[g]) r_mem[r_wptr] <= in_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            r_xfer <= '0;
        else if (in_valid && in_ready)
            r_xfer <= r_xfer + 8'd1;
    end

    assign xfer_cnt  = r_xfer;
    assign out_data0 = w_head[0];
    assign out_data1 = w_head[1];
    assign out_data2 = w_head[2];
    assign out_data3 = w_head[3];
endmodule

// File: tb/tb_demux4_fifo.sv
// tb/tb_demux4_fifo.sv - self-checking bench for demux4_fifo (W=2, DEPTH=2).
module tb_demux4_fifo;
    localparam int W     = 2;
    localparam int DEPTH = 2;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [1:0]   in_sel = 2'd0;
    logic [W-1:0] in_data = '0;
    logic [3:0]   out_valid;
    logic [3:0]   out_ready = 4'b0000;
    logic [W-1:0] out_data0, out_data1, out_data2, out_data3;
    logic [7:0]   xfer_cnt;

    demux4_fifo #(.W(W), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_sel(in_sel), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_data0(out_data0), .out_data1(out_data1),
        .out_data2(out_data2), .out_data3(out_data3),
        .xfer_cnt(xfer_cnt)
    );

    always #5 clk = ~clk;

    logic [W-1:0] w_od [4];
    assign w_od[0] = out_data0;
    assign w_od[1] = out_data1;
    assign w_od[2] = out_data2;
    assign w_od[3] = out_data3;

    typedef logic [W-1:0] beat_q_t [$];
    beat_q_t sb [4];
    logic [7:0] m_cnt = 8'd0;

    int n_vec = 0;
    int n_err = 0;

    typedef struct {
        logic         v;
        logic [1:0]   sel;
        logic [W-1:0] d;
        logic [3:0]   ordy;
        logic         exp_rdy;
        logic [3:0]   exp_ov;
        logic [7:0]   exp_cnt;
    } vec_t;
    vec_t tbl [21];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Drive one cycle starting just after a negedge; compare against the queue model, then clock.
    task automatic cycle(input logic v, input logic [1:0] s, input logic [W-1:0] d, input logic [3:0] ordy);
        logic [3:0] mov;
        logic       mrdy;
        in_valid = v; in_sel = s; in_data = d; out_ready = ordy;
        #1;
        for (int i = 0; i < 4; i++) mov[i] = (sb[i].size() != 0);
        mrdy = (sb[s].size() < DEPTH);
        chk("in_ready", 32'(in_ready), 32'(mrdy));
        chk("out_valid", 32'(out_valid), 32'(mov));
        chk("xfer_cnt", 32'(xfer_cnt), 32'(m_cnt));
        for (int i = 0; i < 4; i++)
            if (mov[i]) chk($sformatf("out_data%0d", i), 32'(w_od[i]), 32'(sb[i][0]));
        @(posedge clk);
        for (int i = 0; i < 4; i++)
            if (mov[i] && ordy[i]) void'(sb[i].pop_front());
        if (v && mrdy) begin
            sb[s].push_back(d);
            m_cnt = m_cnt + 8'd1;
        end
        @(negedge clk);
    endtask

    task automatic model_clear();
        for (int i = 0; i < 4; i++) sb[i].delete();
        m_cnt = 8'd0;
    endtask

    initial begin
        tbl[0]  = '{1'b1, 2'd2, 2'b11, 4'b0000, 1'b1, 4'b0000, 8'd0};
        tbl[1]  = '{1'b0, 2'd0, 2'b00, 4'b0000, 1'b1, 4'b0100, 8'd1};
        tbl[2]  = '{1'b1, 2'd1, 2'b01, 4'b0000, 1'b1, 4'b0100, 8'd1};
        tbl[3]  = '{1'b1, 2'd1, 2'b10, 4'b0000, 1'b1, 4'b0110, 8'd2};
        tbl[4]  = '{1'b1, 2'd1, 2'b11, 4'b0000, 1'b0, 4'b0110, 8'd3};
        tbl[5]  = '{1'b1, 2'd1, 2'b11, 4'b0010, 1'b0, 4'b0110, 8'd3};
        tbl[6]  = '{1'b1, 2'd1, 2'b11, 4'b0010, 1'b1, 4'b0110, 8'd3};
        tbl[7]  = '{1'b0, 2'd1, 2'b00, 4'b0010, 1'b1, 4'b0110, 8'd4};
        tbl[8]  = '{1'b0, 2'd1, 2'b00, 4'b0000, 1'b1, 4'b0100, 8'd4};
        tbl[9]  = '{1'b1, 2'd0, 2'b00, 4'b0000, 1'b1, 4'b0100, 8'd4};
        tbl[10] = '{1'b1, 2'd0, 2'b01, 4'b0000, 1'b1, 4'b0101, 8'd5};
        tbl[11] = '{1'b1, 2'd0, 2'b10, 4'b0000, 1'b0, 4'b0101, 8'd6};
        tbl[12] = '{1'b1, 2'd3, 2'b10, 4'b0000, 1'b1, 4'b0101, 8'd6};
        tbl[13] = '{1'b0, 2'd0, 2'b00, 4'b0000, 1'b0, 4'b1101, 8'd7};
        tbl[14] = '{1'b1, 2'd2, 2'b01, 4'b0100, 1'b1, 4'b1101, 8'd7};
        tbl[15] = '{1'b0, 2'd2, 2'b00, 4'b0000, 1'b1, 4'b1101, 8'd8};
        tbl[16] = '{1'b1, 2'd2, 2'b10, 4'b0000, 1'b1, 4'b1101, 8'd8};
        tbl[17] = '{1'b0, 2'd2, 2'b00, 4'b0000, 1'b0, 4'b1101, 8'd9};
        tbl[18] = '{1'b0, 2'd0, 2'b00, 4'b1111, 1'b0, 4'b1101, 8'd9};
        tbl[19] = '{1'b0, 2'd0, 2'b00, 4'b1111, 1'b1, 4'b0101, 8'd9};
        tbl[20] = '{1'b0, 2'd0, 2'b00, 4'b0000, 1'b1, 4'b0000, 8'd9};

        // Reset state
        @(negedge clk);
        @(negedge clk);
        #1;
        chk("rst_out_valid", 32'(out_valid), 32'h0);
        chk("rst_xfer_cnt", 32'(xfer_cnt), 32'h0);
        chk("rst_in_ready", 32'(in_ready), 32'h1);
        chk("rst_out_data0", 32'(out_data0), 32'h0);
        @(negedge clk);
        rst = 1'b0;
        model_clear();

        // Directed table: single push, ch1 fill/stall/drain, ch0 stalled with ch3 traffic, push+pop on ch2
        for (int k = 0; k < 21; k++) begin
            in_valid = tbl[k].v; in_sel = tbl[k].sel; in_data = tbl[k].d; out_ready = tbl[k].ordy;
            #1;
            chk($sformatf("tbl%0d_in_ready", k), 32'(in_ready), 32'(tbl[k].exp_rdy));
            chk($sformatf("tbl%0d_out_valid", k), 32'(out_valid), 32'(tbl[k].exp_ov));
            chk($sformatf("tbl%0d_xfer_cnt", k), 32'(xfer_cnt), 32'(tbl[k].exp_cnt));
            cycle(tbl[k].v, tbl[k].sel, tbl[k].d, tbl[k].ordy);
        end

        // Drained channels keep presenting their last head
        #1;
        chk("hold_out_data0", 32'(out_data0), 32'h1);
        chk("hold_out_data1", 32'(out_data1), 32'h3);
        chk("hold_out_data2", 32'(out_data2), 32'h2);
        chk("hold_out_data3", 32'(out_data3), 32'h2);

        // Counter wrap: 256 then 257 accepted beats from reset
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        model_clear();
        for (int k = 0; k < 256; k++)
            cycle(1'b1, 2'(k % 4), W'($urandom), 4'b1111);
        #1;
        chk("xfer_cnt_256", 32'(xfer_cnt), 32'h0);
        cycle(1'b1, 2'd1, 2'b10, 4'b1111);
        #1;
        chk("xfer_cnt_257", 32'(xfer_cnt), 32'h1);

        // Asynchronous reset between edges with every channel occupied
        cycle(1'b0, 2'd0, 2'b00, 4'b1111);
        for (int i = 0; i < 4; i++) cycle(1'b1, 2'(i), 2'(i), 4'b0000);
        in_valid = 1'b0;
        #1;
        chk("pre_rst_out_valid", 32'(out_valid), 32'hf);
        #1;
        rst = 1'b1;
        #1;
        chk("async_rst_out_valid", 32'(out_valid), 32'h0);
        chk("async_rst_xfer_cnt", 32'(xfer_cnt), 32'h0);
        chk("async_rst_out_data3", 32'(out_data3), 32'h0);
        chk("async_rst_in_ready", 32'(in_ready), 32'h1);
        @(negedge clk);
        rst = 1'b0;
        model_clear();
        for (int k = 0; k < 3; k++) cycle(1'b0, 2'(k), 2'b11, 4'b1111);
        cycle(1'b1, 2'd3, 2'b01, 4'b0000);
        cycle(1'b0, 2'd3, 2'b00, 4'b1000);
        cycle(1'b0, 2'd3, 2'b00, 4'b0000);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
